// File: rtl/msync_ctrl.sv
// rtl/msync_ctrl.sv - m-sequence epoch acquisition/verify/track controller with per-period bit decode
// Optional build macro LOCK_STATS_EN adds a saturating lock-loss counter output.
module msync_ctrl #(
    parameter int SEQ_LEN    = 31,
    parameter int THRESH_HI  = 56,
    parameter int THRESH_LO  = 6,
    parameter int VERIFY_CNT = 3,
    parameter int MISS_MAX   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_clr,
    input  logic [7:0] corr,
`ifdef LOCK_STATS_EN
    output logic [7:0] lock_loss_cnt,
`endif
    output logic       bit_out,
    output logic       bit_valid,
    output logic       epoch,
    output logic       locked,
    output logic [1:0] state
);

    localparam int CW = $clog2(SEQ_LEN);
    localparam int HW = $clog2(VERIFY_CNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0]    TH_HI     = 8'(THRESH_HI);
    localparam logic [7:0]    TH_LO     = 8'(THRESH_LO);
    localparam logic [CW-1:0] CHIP_LAST = CW'(SEQ_LEN - 1);
    localparam logic [HW-1:0] HIT_LAST  = HW'(VERIFY_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] chip_q, chip_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          bit_out_q, bit_out_d;
    logic          bit_valid_q, bit_valid_d;
    logic          locked_q, locked_d;

    logic peak1, peak0, is_peak, is_epoch;

    assign peak1    = (corr >= TH_HI);
    assign peak0    = (corr <= TH_LO);
    assign is_peak  = peak1 | peak0;
    assign is_epoch = (chip_q == CHIP_LAST);

    always_comb begin
        state_d     = state_q;
        chip_d      = chip_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        locked_d    = locked_q;

        if (sync_clr) begin
            state_d   = ST_SEARCH;
            chip_d    = '0;
            hit_d     = '0;
            miss_d    = '0;
            bit_out_d = 1'b0;
            locked_d  = 1'b0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    // Any cycle may be the epoch; the first detection counts as one verify hit.
                    if (is_peak) begin
                        chip_d = '0;
                        hit_d  = HW'(1);
                        miss_d = '0;
                        if (VERIFY_CNT == 1) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    chip_d = is_epoch ? '0 : chip_q + 1'b1;
                    if (is_epoch) begin
                        if (is_peak) begin
                            hit_d = hit_q + 1'b1;
                            if (hit_q == HIT_LAST) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                                miss_d   = '0;
                            end
                        end else begin
                            state_d = ST_SEARCH;
                            chip_d  = '0;
                            hit_d   = '0;
                            miss_d  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    chip_d = is_epoch ? '0 : chip_q + 1'b1;
                    if (is_epoch) begin
                        if (is_peak) begin
                            bit_out_d   = peak1;
                            bit_valid_d = 1'b1;
                            miss_d      = '0;
                        end else if (miss_q == MISS_LAST) begin
                            state_d  = ST_SEARCH;
                            locked_d = 1'b0;
                            chip_d   = '0;
                            hit_d    = '0;
                            miss_d   = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_SEARCH;
                    chip_d   = '0;
                    hit_d    = '0;
                    miss_d   = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            chip_q      <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            chip_q      <= chip_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            locked_q    <= locked_d;
        end
    end

`ifdef LOCK_STATS_EN
    logic [7:0] loss_q;
    logic       loss_evt;

    // Only miss-driven drops count; sync_clr restarts are deliberate and leave the tally alone.
    assign loss_evt = (state_q == ST_LOCKED) && (state_d == ST_SEARCH) && !sync_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign lock_loss_cnt = loss_q;
`endif

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign locked    = locked_q;
    assign state     = state_q;
    assign epoch     = (state_q != ST_SEARCH) && is_epoch;

endmodule

// File: tb/tb_msync_ctrl.sv
// tb/tb_msync_ctrl.sv - directed self-checking bench for msync_ctrl
module tb_msync_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync_clr = 1'b0;
    logic [7:0] corr = 8'd31;
    logic       bit_out, bit_valid, epoch, locked;
    logic [1:0] state;
`ifdef LOCK_STATS_EN
    logic [7:0] lock_loss_cnt;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int valid_seen;
    int last_valid_cyc;
    int det_cyc;

    always #5 clk = ~clk;

    msync_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .sync_clr  (sync_clr),
        .corr      (corr),
`ifdef LOCK_STATS_EN
        .lock_loss_cnt(lock_loss_cnt),
`endif
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .epoch     (epoch),
        .locked    (locked),
        .state     (state)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply corr for one edge, then settle just after that edge.
    task automatic step(input logic [7:0] c);
        corr = c;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Feed uncorrelated chips until the epoch strobe shows, counting any stray bit_valid.
    task automatic run_to_epoch();
        int n;
        n = 0;
        valid_seen = 0;
        while (!epoch && n < 40) begin
            step(8'd31);
            if (bit_valid) valid_seen++;
            n++;
        end
        chk("epoch_reached", int'(epoch), 1);
    endtask

    task automatic acquire();
        step(8'd62);
        chk("acq_verify", int'(state), 1);
        run_to_epoch();
        step(8'd58);
        chk("acq_still_verify", int'(state), 1);
        run_to_epoch();
        step(8'd62);
        chk("acq_locked", int'(locked), 1);
        chk("acq_state", int'(state), 2);
        chk("acq_no_bit", int'(bit_valid), 0);
    endtask

    initial begin
        logic [7:0] vec [4];
        vec[0] = 8'd62; vec[1] = 8'd0; vec[2] = 8'd58; vec[3] = 8'd5;

        // reset held with a peak present
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(8'd62);
            chk("rst_state", int'(state), 0);
            chk("rst_outs", int'({bit_out, bit_valid, epoch, locked}), 0);
        end
        rst = 1'b0;

        // acquisition: detect, two epoch confirms
        acquire();
        chk("acq_valid_before_lock", valid_seen, 0);

        // tracking: bits follow polarity, one pulse per period
        last_valid_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            run_to_epoch();
            chk("trk_no_stray_valid", valid_seen, 0);
            step(vec[k]);
            chk("trk_valid", int'(bit_valid), 1);
            chk("trk_bit", int'(bit_out), (vec[k] >= 8'd56) ? 1 : 0);
            if (last_valid_cyc >= 0) chk("trk_period", cyc - last_valid_cyc, 31);
            last_valid_cyc = cyc;
        end

        // two misses drop lock
        run_to_epoch();
        step(8'd31);
        chk("miss1_valid", int'(bit_valid), 0);
        chk("miss1_locked", int'(locked), 1);
        run_to_epoch();
        step(8'd31);
        chk("miss2_locked", int'(locked), 0);
        chk("miss2_state", int'(state), 0);
        chk("miss2_bit_hold", int'(bit_out), 0);
        chk("miss2_valid", int'(bit_valid), 0);
        step(8'd31);
        chk("search_no_epoch", int'(epoch), 0);
`ifdef LOCK_STATS_EN
        chk("loss_cnt_1", int'(lock_loss_cnt), 1);
`endif

        // one miss then a true peak keeps lock
        acquire();
        run_to_epoch();
        step(8'd31);
        run_to_epoch();
        step(8'd62);
        chk("recover_valid", int'(bit_valid), 1);
        chk("recover_bit", int'(bit_out), 1);
        chk("recover_locked", int'(locked), 1);

        // sync_clr on an epoch with a peak: no bit, back to SEARCH
        run_to_epoch();
        sync_clr = 1'b1;
        step(8'd62);
        sync_clr = 1'b0;
        chk("clr_valid", int'(bit_valid), 0);
        chk("clr_state", int'(state), 0);
        chk("clr_locked", int'(locked), 0);
`ifdef LOCK_STATS_EN
        chk("loss_cnt_after_clr", int'(lock_loss_cnt), 1);
`endif

        // off-epoch peak in VERIFY ignored; miss at epoch returns to SEARCH
        step(8'd62);
        det_cyc = cyc;
        chk("v_detect", int'(state), 1);
        for (int i = 0; i < 9; i++) step(8'd31);
        step(8'd62);
        chk("v_offepoch_state", int'(state), 1);
        run_to_epoch();
        chk("v_still_verify", int'(state), 1);
        step(8'd31);
        chk("v_epoch_offset", cyc - det_cyc, 31);
        chk("v_drop_state", int'(state), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
